// File: rtl/product_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// product_accumulator_pkg
// Shared definitions for the product accumulator:
//   - FSM state encoding (S_ACC collects products, S_OUT presents a sum)
//   - default widths for products, accumulator and term counter
//   - sat_add: width-generic saturating add used by the accumulator
// ---------------------------------------------------------------------------
package product_accumulator_pkg;

  localparam int PROD_W_DEF  = 16;
  localparam int ACC_W_DEF   = 24;
  localparam int CNT_W_DEF   = 4;
  localparam int N_TERMS_DEF = 8;

  // Widest accumulator sat_add can handle.
  localparam int SAT_MAX_W = 64;

  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  // Adds two values that both fit in w bits (w < SAT_MAX_W).
  // Result: bit [SAT_MAX_W] = carry out of bit w-1, bits [w-1:0] = sum,
  // forced to all ones when the add carried.
  function automatic logic [SAT_MAX_W:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int                   w
  );
    logic [SAT_MAX_W:0] s;
    logic [SAT_MAX_W:0] mask;
    logic               carry;
    s     = {1'b0, a} + {1'b0, b};
    // Both operands are below 2^w, so s >> w is either 0 or 1.
    carry = |(s >> w);
    mask  = ~({(SAT_MAX_W+1){1'b1}} << w);
    if (carry) begin
      sat_add = {1'b1, mask[SAT_MAX_W-1:0]};
    end else begin
      sat_add = {1'b0, s[SAT_MAX_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/product_accumulator_rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
// Registered rising-edge detector. o_rise is high in any cycle where i_d is
// high and was low at the previous clock edge, so a level held high yields a
// single detection.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (history register cleared to 0)
//   i_d    level input
//   o_rise i_d & ~(i_d delayed by one clock)
// ---------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
// Captures finished products from the sequential multiplier on the rising
// edge of its level done, sums N_TERMS of them with saturation, and presents
// each completed sum on a valid/ready port. While a sum is waiting one early
// product can be parked in a pending buffer; further products are dropped
// and flagged.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   clear      synchronous flush of partial sum, pending product and flags
//   prod_in    product from multiplier, sampled only on a capture
//   prod_done  multiplier done level; only its rising edge captures
//   next_op    one-cycle pulse after each product is absorbed
//   sum_out    completed sum
//   sum_valid  completed sum available
//   sum_ready  consumer ready
//   ovf        saturation happened in the group held on sum_out
//   drop_err   sticky: a product was lost with the pending buffer full
//   dbg_state  current FSM state (S_ACC=0, S_OUT=1)
//
// Output handshake: a sum transfers on a clock edge where sum_valid and
// sum_ready are both 1. Once raised, sum_valid stays 1 and sum_out/ovf stay
// constant until that transfer edge; sum_valid never depends on sum_ready.
// ---------------------------------------------------------------------------
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,   // must be >= PROD_W
  parameter int N_TERMS = N_TERMS_DEF, // 1 .. 2**CNT_W
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_done,
  output logic              next_op,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              ovf,
  output logic              drop_err,
  output logic              dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  // Registered state
  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [PROD_W-1:0]  r_pend;
  logic               r_pend_v;
  logic [ACC_W-1:0]   r_sum;
  logic               r_sum_valid;
  logic               r_next_op;
  logic               r_ovf;
  logic               r_drop_err;

  // Next-state values
  state_t             w_state_n;
  logic [ACC_W-1:0]   w_acc_n;
  logic [CNT_W-1:0]   w_cnt_n;
  logic [PROD_W-1:0]  w_pend_n;
  logic               w_pend_v_n;
  logic [ACC_W-1:0]   w_sum_n;
  logic               w_sum_valid_n;
  logic               w_next_op_n;
  logic               w_ovf_n;
  logic               w_drop_err_n;

  logic               w_cap;
  logic [PROD_W-1:0]  w_add_val;
  logic [SAT_MAX_W:0] w_sat;
  logic [ACC_W-1:0]   w_sat_sum;
  logic               w_sat_carry;
  logic               w_unused_sat;

  rise_detect u_done_rise (
    .clk    (clk),
    .rst_n  (reset),
    .i_d    (prod_done),
    .o_rise (w_cap)
  );

  // A parked product is always older than anything arriving now, so it is
  // absorbed first.
  assign w_add_val    = r_pend_v ? r_pend : prod_in;
  assign w_sat        = sat_add(SAT_MAX_W'(r_acc), SAT_MAX_W'(w_add_val), ACC_W);
  assign w_sat_sum    = w_sat[ACC_W-1:0];
  assign w_sat_carry  = w_sat[SAT_MAX_W];
  assign w_unused_sat = ^w_sat[SAT_MAX_W-1:ACC_W];

  always_comb begin
    w_state_n     = r_state;
    w_acc_n       = r_acc;
    w_cnt_n       = r_cnt;
    w_pend_n      = r_pend;
    w_pend_v_n    = r_pend_v;
    w_sum_n       = r_sum;
    w_sum_valid_n = r_sum_valid;
    w_next_op_n   = 1'b0;
    w_ovf_n       = r_ovf;
    w_drop_err_n  = r_drop_err;

    if (clear) begin
      w_state_n     = S_ACC;
      w_acc_n       = '0;
      w_cnt_n       = '0;
      w_pend_v_n    = 1'b0;
      w_sum_valid_n = 1'b0;
      w_ovf_n       = 1'b0;
      w_drop_err_n  = 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (r_pend_v || w_cap) begin
            w_acc_n     = w_sat_sum;
            w_ovf_n     = r_ovf | w_sat_carry;
            w_next_op_n = 1'b1;
            // Pending slot was the source; refill it with a same-cycle capture.
            if (r_pend_v) begin
              w_pend_v_n = w_cap;
              if (w_cap) begin
                w_pend_n = prod_in;
              end
            end
            if (r_cnt == LAST_CNT) begin
              w_state_n     = S_OUT;
              w_cnt_n       = '0;
              w_sum_n       = w_sat_sum;
              w_sum_valid_n = 1'b1;
            end else begin
              w_cnt_n = r_cnt + CNT_W'(1);
            end
          end
        end
        S_OUT: begin
          if (r_sum_valid && sum_ready) begin
            w_state_n     = S_ACC;
            w_sum_valid_n = 1'b0;
            w_acc_n       = '0;
            w_cnt_n       = '0;
            w_ovf_n       = 1'b0;
          end
          // No absorbing here; one product may wait, the next is lost.
          if (w_cap) begin
            if (!r_pend_v) begin
              w_pend_n   = prod_in;
              w_pend_v_n = 1'b1;
            end else begin
              w_drop_err_n = 1'b1;
            end
          end
        end
        default: begin
          w_state_n = S_ACC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_pend      <= '0;
      r_pend_v    <= 1'b0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_next_op   <= 1'b0;
      r_ovf       <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_acc       <= w_acc_n;
      r_cnt       <= w_cnt_n;
      r_pend      <= w_pend_n;
      r_pend_v    <= w_pend_v_n;
      r_sum       <= w_sum_n;
      r_sum_valid <= w_sum_valid_n;
      r_next_op   <= w_next_op_n;
      r_ovf       <= w_ovf_n;
      r_drop_err  <= w_drop_err_n;
    end
  end

  assign next_op   = r_next_op;
  assign sum_out   = r_sum;
  assign sum_valid = r_sum_valid;
  assign ovf       = r_ovf;
  assign drop_err  = r_drop_err;
  assign dbg_state = r_state;

endmodule
